// File: rtl/fpall_pkg.sv
// Shared types for the fpall issue/result-collection slice: formats, opcodes,
// result record and the latency/tag-width constants the shared FP unit expects.
package fpall_pkg;

    typedef enum logic [1:0] {
        FP32 = 2'd0,
        FP16 = 2'd1
    } fp_fmt_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_MIN = 3'd3,
        OP_MAX = 3'd4
    } fp_op_e;

    localparam int FPALL_TAG_W = 4;
    localparam int FPALL_LAT   = 2;

    typedef struct packed {
        logic [31:0]            r;
        logic [FPALL_TAG_W-1:0] tag;
        fp_fmt_e                fmt;
    } fpall_res_t;

endpackage

// File: rtl/fpall_result_fifo.sv
// In-order result queue: circular buffer with naturally wrapping pointers and a
// count one bit wider than the pointers so that full and empty are distinct.
module fpall_result_fifo
    import fpall_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  fpall_res_t       push_data_i,
    input  logic             pop_i,
    output logic [PTR_W:0]   count_o,
    output fpall_res_t       head_o
);

    fpall_res_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Next-state for pointers and count; a simultaneous push and pop leaves the count alone.
    always_comb begin
        do_pop_s  = pop_i && (cnt_q != '0);
        do_push_s = push_i && ((cnt_q != (PTR_W+1)'(DEPTH)) || do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + {{PTR_W{1'b0}}, 1'b1};
            2'b01:   cnt_d = cnt_q - {{PTR_W{1'b0}}, 1'b1};
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage; contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fpall_issue_ctrl.sv
// Issue and result-collection stage around the fixed-latency shared FP unit.
// Accepts only while in-flight ops plus queued results leave a free FIFO slot.
module fpall_issue_ctrl
    import fpall_pkg::*;
#(
    parameter int LAT        = FPALL_LAT,
    parameter int FIFO_DEPTH = 8,
    parameter int TAG_W      = FPALL_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  fp_fmt_e          in_fmt,
    input  fp_op_e           in_op,
    input  logic [31:0]      in_x,
    input  logic [31:0]      in_y,
    input  logic [TAG_W-1:0] in_tag,
    output fp_fmt_e          fu_fmt,
    output fp_op_e           fu_opcode,
    output logic [31:0]      fu_x,
    output logic [31:0]      fu_y,
    input  logic [31:0]      fu_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_r,
    output logic [TAG_W-1:0] out_tag,
    output fp_fmt_e          out_fmt,
    output logic             busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IF_W  = $clog2(LAT + 2);
    localparam int SUM_W = CNT_W + IF_W;

    logic [LAT:0]     vld_q, vld_d;
    logic [TAG_W-1:0] tag_q [LAT+1];
    fp_fmt_e          fmt_q [LAT+1];

    fp_fmt_e          fu_fmt_q, fu_fmt_d;
    fp_op_e           fu_op_q, fu_op_d;
    logic [31:0]      fu_x_q, fu_x_d;
    logic [31:0]      fu_y_q, fu_y_d;

    logic             accept_s;
    logic [IF_W-1:0]  inflight_s;
    logic [CNT_W-1:0] fifo_cnt_s;
    logic [SUM_W-1:0] credit_s;
    fpall_res_t       push_data_s;
    fpall_res_t       head_s;

    assign accept_s = in_valid && in_ready;

    // Operand registers load only on accept; otherwise the unit sees stale operands whose result is ignored.
    always_comb begin
        fu_fmt_d = fu_fmt_q;
        fu_op_d  = fu_op_q;
        fu_x_d   = fu_x_q;
        fu_y_d   = fu_y_q;
        if (accept_s) begin
            fu_fmt_d = in_fmt;
            fu_op_d  = in_op;
            fu_x_d   = in_x;
            fu_y_d   = in_y;
        end else begin
            fu_fmt_d = fu_fmt_q;
            fu_op_d  = fu_op_q;
            fu_x_d   = fu_x_q;
            fu_y_d   = fu_y_q;
        end
        vld_d = {vld_q[LAT-1:0], accept_s};
    end

    // Operand and valid-pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fu_fmt_q <= FP16;
            fu_op_q  <= OP_ADD;
            fu_x_q   <= 32'h0000_0000;
            fu_y_q   <= 32'h0000_0000;
            vld_q    <= '0;
        end else begin
            fu_fmt_q <= fu_fmt_d;
            fu_op_q  <= fu_op_d;
            fu_x_q   <= fu_x_d;
            fu_y_q   <= fu_y_d;
            vld_q    <= vld_d;
        end
    end

    // Tag/format shadow of the valid pipeline; shifts every cycle like the unit itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= LAT; i++) begin
                tag_q[i] <= '0;
                fmt_q[i] <= FP16;
            end
        end else begin
            tag_q[0] <= in_tag;
            fmt_q[0] <= in_fmt;
            for (int i = 1; i <= LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
                fmt_q[i] <= fmt_q[i-1];
            end
        end
    end

    // In-flight count, credit check and the record captured from the unit's output.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i <= LAT; i++) begin
            inflight_s = inflight_s + IF_W'(vld_q[i]);
        end
        credit_s        = SUM_W'(inflight_s) + SUM_W'(fifo_cnt_s);
        push_data_s.r   = fu_r;
        push_data_s.tag = FPALL_TAG_W'(tag_q[LAT]);
        push_data_s.fmt = fmt_q[LAT];
    end

    assign in_ready = credit_s < SUM_W'(FIFO_DEPTH);

    fpall_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (vld_q[LAT]),
        .push_data_i (push_data_s),
        .pop_i       (out_ready),
        .count_o     (fifo_cnt_s),
        .head_o      (head_s)
    );

    assign fu_fmt    = fu_fmt_q;
    assign fu_opcode = fu_op_q;
    assign fu_x      = fu_x_q;
    assign fu_y      = fu_y_q;
    assign out_valid = fifo_cnt_s != '0;
    assign out_r     = head_s.r;
    assign out_tag   = TAG_W'(head_s.tag);
    assign out_fmt   = head_s.fmt;
    assign busy      = (inflight_s != '0) || (fifo_cnt_s != '0);

endmodule

// File: tb/tb_fpall_issue_ctrl.sv
// Directed bench for fpall_issue_ctrl with a behavioural 2-cycle bf16x2 adder
// standing in for the shared FP unit; results are scoreboarded in accept order.
module tb_fpall_issue_ctrl;
    import fpall_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    fp_fmt_e     in_fmt;
    fp_op_e      in_op;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic [3:0]  in_tag;
    fp_fmt_e     fu_fmt;
    fp_op_e      fu_opcode;
    logic [31:0] fu_x;
    logic [31:0] fu_y;
    logic [31:0] fu_r;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_r;
    logic [3:0]  out_tag;
    fp_fmt_e     out_fmt;
    logic        busy;

    int          checks   = 0;
    int          failures = 0;
    int          acc_cnt  = 0;
    int          pop_cnt  = 0;
    logic [31:0] exp_r [$];
    logic [3:0]  exp_tag [$];
    logic [31:0] p1_q, p2_q;

    always #5 clk = ~clk;

    fpall_issue_ctrl #(.LAT(2), .FIFO_DEPTH(8), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_op(in_op), .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
        .fu_fmt(fu_fmt), .fu_opcode(fu_opcode), .fu_x(fu_x), .fu_y(fu_y), .fu_r(fu_r),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_tag(out_tag),
        .out_fmt(out_fmt), .busy(busy)
    );

    // bf16 add, round-to-nearest-even, subnormals flushed, inputs kept away from inf/nan.
    function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] big, sml, rem;
        logic [31:0] mb, ms, sh, s;
        logic [8:0]  m;
        int          eb, es, d, e;
        if (a[14:7] == 8'd0) return (b[14:7] == 8'd0) ? {a[15] & b[15], 15'd0} : b;
        if (b[14:7] == 8'd0) return a;
        big = a;
        sml = b;
        if (b[14:0] > a[14:0]) begin
            big = b;
            sml = a;
        end
        eb = int'(big[14:7]);
        es = int'(sml[14:7]);
        d  = eb - es;
        mb = {8'd0, 1'b1, big[6:0], 16'd0};
        ms = {8'd0, 1'b1, sml[6:0], 16'd0};
        if (d >= 32) begin
            sh = 32'd1;
        end else begin
            sh = ms >> d;
            if ((sh << d) != ms) sh = sh | 32'd1;
        end
        s = (big[15] == sml[15]) ? mb + sh : mb - sh;
        if (s == 32'd0) return 16'h0000;
        e = eb;
        if (s >= 32'h0100_0000) begin
            s = (s >> 1) | {31'd0, s[0]};
            e = e + 1;
        end
        while (s < 32'h0080_0000) begin
            s = s << 1;
            e = e - 1;
        end
        rem = s[15:0];
        m   = {1'b0, s[23:16]};
        if ((rem > 16'h8000) || ((rem == 16'h8000) && m[0])) m = m + 9'd1;
        if (m[8]) begin
            m = 9'h080;
            e = e + 1;
        end
        if (e <= 0) return {big[15], 15'd0};
        if (e >= 255) return {big[15], 8'hFF, 7'd0};
        return {big[15], e[7:0], m[6:0]};
    endfunction

    function automatic logic [31:0] bf16x2_add(input logic [31:0] x, input logic [31:0] y);
        return {bf16_add(x[31:16], y[31:16]), bf16_add(x[15:0], y[15:0])};
    endfunction

    function automatic logic [15:0] rnd_bf16();
        logic [7:0] ex;
        ex = 8'($urandom_range(140, 110));
        return {1'($urandom_range(1, 0)), ex, 7'($urandom_range(127, 0))};
    endfunction

    // Stand-in FP unit: result valid LAT=2 posedges after operands are presented.
    always @(posedge clk) begin
        p1_q <= bf16x2_add(fu_x, fu_y);
        p2_q <= p1_q;
    end
    assign fu_r = p2_q;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, expv);
        end
    endtask

    // One clock: book accepts and pops visible now, then advance to #1 after the next edge.
    task automatic tick();
        if (!rst && in_valid && in_ready) begin
            exp_r.push_back(bf16x2_add(in_x, in_y));
            exp_tag.push_back(in_tag);
            acc_cnt++;
        end
        if (!rst && out_valid && out_ready) begin
            pop_cnt++;
            chk("result_expected", 64'(exp_r.size() != 0), 64'd1);
            if (exp_r.size() != 0) begin
                chk("result_tag", 64'(out_tag), 64'(exp_tag.pop_front()));
                chk("result_r", 64'(out_r), 64'(exp_r.pop_front()));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 40 && exp_r.size() != 0; k++) tick();
        chk("drain_left", 64'(exp_r.size()), 64'd0);
        tick();
        tick();
    endtask

    task automatic set_rand_op(input logic [3:0] tag);
        in_fmt = FP16;
        in_op  = OP_ADD;
        in_x   = {rnd_bf16(), rnd_bf16()};
        in_y   = {rnd_bf16(), rnd_bf16()};
        in_tag = tag;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base_acc, base_pop, drops;
        logic [31:0] snap_r;
        logic [3:0]  snap_tag;
        logic        stalled;

        // Reset held 3 cycles with random request inputs.
        rst       = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'($urandom_range(1, 0));
            set_rand_op(4'($urandom_range(15, 0)));
            in_op = fp_op_e'(3'($urandom_range(4, 0)));
            @(posedge clk);
            #1;
        end
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fu_opcode", 64'(fu_opcode), 64'(OP_ADD));
        chk("rst_fu_x", 64'(fu_x), 64'd0);
        chk("rst_fu_y", 64'(fu_y), 64'd0);
        chk("rst_fu_fmt", 64'(fu_fmt), 64'(FP16));
        rst = 1'b0;

        // Single op, offered in the first cycle after reset.
        in_valid = 1'b1;
        in_fmt   = FP16;
        in_op    = OP_ADD;
        in_x     = 32'h3F80_3F80;
        in_y     = 32'h3F80_4000;
        in_tag   = 4'd3;
        chk("single_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("single_fu_x", 64'(fu_x), 64'h3F80_3F80);
        chk("single_fu_y", 64'(fu_y), 64'h3F80_4000);
        chk("single_busy", 64'(busy), 64'd1);
        for (int c = 1; c < 4; c++) begin
            chk("single_early_valid", 64'(out_valid), 64'd0);
            tick();
        end
        chk("single_valid_c4", 64'(out_valid), 64'd1);
        chk("single_r", 64'(out_r), 64'h4000_4040);
        chk("single_tag", 64'(out_tag), 64'd3);
        chk("single_fmt", 64'(out_fmt), 64'(FP16));
        tick();
        chk("single_after_valid", 64'(out_valid), 64'd0);
        chk("single_after_busy", 64'(busy), 64'd0);

        // Backpressure: credits allow exactly FIFO_DEPTH accepts.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        base_acc  = acc_cnt;
        base_pop  = pop_cnt;
        for (int k = 0; k < 14; k++) begin
            set_rand_op(4'(acc_cnt - base_acc));
            tick();
        end
        chk("bp_accepts", 64'(acc_cnt - base_acc), 64'd8);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_head_tag", 64'(out_tag), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 80 && ((acc_cnt - base_acc) < 16 || exp_r.size() != 0); k++) begin
            in_valid = (acc_cnt - base_acc) < 16;
            set_rand_op(4'(acc_cnt - base_acc));
            tick();
        end
        chk("bp_total_accepts", 64'(acc_cnt - base_acc), 64'd16);
        drain();
        chk("bp_total_results", 64'(pop_cnt - base_pop), 64'd16);

        // Streaming: 64 back-to-back adds with no backpressure.
        base_acc = acc_cnt;
        base_pop = pop_cnt;
        drops    = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            set_rand_op(4'(i));
            if (!in_ready) drops++;
            tick();
        end
        chk("stream_ready_drops", 64'(drops), 64'd0);
        chk("stream_accepts", 64'(acc_cnt - base_acc), 64'd64);
        drain();
        chk("stream_results", 64'(pop_cnt - base_pop), 64'd64);

        // Stall hold: out_ready alternates while results are queued.
        base_acc  = acc_cnt;
        base_pop  = pop_cnt;
        out_ready = 1'b0;
        for (int k = 0; k < 24; k++) begin
            in_valid = k < 6;
            set_rand_op(4'(4'd5 + 4'(acc_cnt - base_acc)));
            if (k >= 6) out_ready = k[0];
            stalled  = out_valid && !out_ready;
            snap_r   = out_r;
            snap_tag = out_tag;
            tick();
            if (stalled) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_r", 64'(out_r), 64'(snap_r));
                chk("stall_tag", 64'(out_tag), 64'(snap_tag));
            end
        end
        drain();
        chk("stall_results", 64'(pop_cnt - base_pop), 64'd6);

        // Reset while two ops are in flight discards both.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_rand_op(4'd1);
        tick();
        set_rand_op(4'd2);
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        exp_r.delete();
        exp_tag.delete();
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        base_pop = pop_cnt;
        for (int k = 0; k < 6; k++) begin
            chk("midrst_no_out", 64'(out_valid), 64'd0);
            tick();
        end
        in_valid = 1'b1;
        set_rand_op(4'd9);
        tick();
        drain();
        chk("midrst_results", 64'(pop_cnt - base_pop), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
